// File: rtl/regfile_scoreboard.sv
// 32 x 32-bit register file with two bypassed combinational read ports, one write port,
// and a per-register pending-write scoreboard that raises a decode stall.
module regfile_scoreboard #(
   parameter int WIDTH = 32,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             write_en,
   input  logic [AW-1:0]    write_reg,
   input  logic [WIDTH-1:0] write_data,
   input  logic             issue_en,
   input  logic [AW-1:0]    issue_reg,
   input  logic [AW-1:0]    read_reg_a,
   input  logic [AW-1:0]    read_reg_b,
   output logic [WIDTH-1:0] data_a,
   output logic [WIDTH-1:0] data_b,
   output logic             busy_a,
   output logic             busy_b,
   output logic             stall
);

   logic [WIDTH-1:0] r_regs [NREGS];
   logic [NREGS-1:0] r_busy;

   logic w_wr_ok;
   logic w_hit_a;
   logic w_hit_b;
   logic w_wb_a;
   logic w_wb_b;

   // Reset gates the bypass so nothing on the write port leaks out while clr is high.
   assign w_wr_ok = write_en && (write_reg != '0) && !clr;
   assign w_hit_a = w_wr_ok && (write_reg == read_reg_a);
   assign w_hit_b = w_wr_ok && (write_reg == read_reg_b);
   assign w_wb_a  = write_en && (write_reg == read_reg_a);
   assign w_wb_b  = write_en && (write_reg == read_reg_b);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         if (w_wr_ok) begin
            r_regs[write_reg] <= write_data;
         end
         r_busy[0] <= 1'b0;
         // A new issue to the same register outranks the retiring writeback.
         for (int r = 1; r < NREGS; r++) begin
            if (issue_en && (issue_reg == AW'(r))) begin
               r_busy[r] <= 1'b1;
            end else if (write_en && (write_reg == AW'(r))) begin
               r_busy[r] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      data_a = '0;
      data_b = '0;
      if (w_hit_a) begin
         data_a = write_data;
      end else if (!clr && (read_reg_a != '0)) begin
         data_a = r_regs[read_reg_a];
      end
      if (w_hit_b) begin
         data_b = write_data;
      end else if (!clr && (read_reg_b != '0)) begin
         data_b = r_regs[read_reg_b];
      end
   end

   assign busy_a = !clr && r_busy[read_reg_a] && !w_wb_a;
   assign busy_b = !clr && r_busy[read_reg_b] && !w_wb_b;
   assign stall  = busy_a || busy_b;

endmodule
